// File: rtl/fifo_pkg.sv
// Shared types and Gray-code helpers for the dual-clock FIFO controller.
`timescale 1ns/1ps
package fifo_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_flags_t;

  function automatic logic [GRAY_MAX_W-1:0] width_mask(input int unsigned width);
    // A shift by the full word width yields zero, so the subtraction gives all ones.
    return (32'd1 << width) - 32'd1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin,
                                                     input int unsigned width);
    logic [GRAY_MAX_W-1:0] b;
    b = bin & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray,
                                                     input int unsigned width);
    logic [GRAY_MAX_W-1:0] g;
    logic [GRAY_MAX_W-1:0] b;
    g = gray & width_mask(width);
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop bus synchroniser for a Gray-coded pointer entering a new clock domain.
`timescale 1ns/1ps
module fifo_ptr_sync #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned N_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [N_STAGES-1:0][WIDTH-1:0] stage_q;
  logic [N_STAGES-1:0][WIDTH-1:0] stage_d;

  // Shift the incoming Gray value one stage deeper each destination clock.
  always_comb begin
    stage_d = {stage_q[N_STAGES-2:0], i_d};
  end

  // Stage registers, cleared by the destination domain's own reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_q = stage_q[N_STAGES-1];

endmodule

// File: rtl/fifo_async_ctrl.sv
// Pointer, flag and fill-count controller for a dual-clock power-of-two FIFO;
// drives the external dual-port RAM addresses directly.
`timescale 1ns/1ps
module fifo_async_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned ADDR_WIDTH       = $clog2(DEPTH),
  parameter int unsigned N_FLOP_CROSS     = 2,
  parameter int unsigned ALMOST_WR_MARGIN = 1,
  parameter int unsigned ALMOST_RD_MARGIN = 1
) (
  input  logic                  i_wr_clk,
  input  logic                  i_wr_rst_n,
  input  logic                  i_rd_clk,
  input  logic                  i_rd_rst_n,
  input  logic                  i_write,
  input  logic                  i_read,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_wr_full,
  output logic                  o_wr_almost_full,
  output logic                  o_rd_empty,
  output logic                  o_rd_almost_empty,
  output logic [ADDR_WIDTH:0]   o_wr_count,
  output logic [ADDR_WIDTH:0]   o_rd_count,
  output logic                  o_wr_overflow,
  output logic                  o_rd_underflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [PW-1:0] DEPTH_P    = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_LVL  = PW'(DEPTH - ALMOST_WR_MARGIN);
  localparam logic [PW-1:0] AEMPTY_LVL = PW'(ALMOST_RD_MARGIN);

  // write domain
  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] wr_count_q, wr_count_d;
  logic [PW-1:0] rd_gray_sync_s, rd_bin_sync_s;
  logic          wr_full_q, wr_full_d;
  logic          wr_afull_q, wr_afull_d;
  logic          wr_ovf_q, wr_ovf_d;
  logic          wr_accept_s;

  // read domain
  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] rd_count_q, rd_count_d;
  logic [PW-1:0] wr_gray_sync_s, wr_bin_sync_s;
  logic          rd_empty_q, rd_empty_d;
  logic          rd_aempty_q, rd_aempty_d;
  logic          rd_unf_q, rd_unf_d;
  logic          rd_accept_s;

  fifo_flags_t   flags_s;

  fifo_ptr_sync #(.WIDTH(PW), .N_STAGES(N_FLOP_CROSS)) u_wr2rd_sync (
    .i_clk   (i_rd_clk),
    .i_rst_n (i_rd_rst_n),
    .i_d     (wr_gray_q),
    .o_q     (wr_gray_sync_s)
  );

  fifo_ptr_sync #(.WIDTH(PW), .N_STAGES(N_FLOP_CROSS)) u_rd2wr_sync (
    .i_clk   (i_wr_clk),
    .i_rst_n (i_wr_rst_n),
    .i_d     (rd_gray_q),
    .o_q     (rd_gray_sync_s)
  );

  // Writer: flags come from the post-accept pointer so they are valid one edge after the accept.
  always_comb begin
    wr_accept_s = i_write && !wr_full_q;
    if (wr_accept_s) begin
      wr_bin_d = wr_bin_q + PTR_ONE;
    end else begin
      wr_bin_d = wr_bin_q;
    end
    wr_gray_d     = PW'(bin2gray(32'(wr_bin_d), PW));
    rd_bin_sync_s = PW'(gray2bin(32'(rd_gray_sync_s), PW));
    wr_count_d    = wr_bin_d - rd_bin_sync_s;
    wr_full_d     = (wr_count_d == DEPTH_P);
    wr_afull_d    = (wr_count_d >= AFULL_LVL);
    wr_ovf_d      = wr_ovf_q || (i_write && wr_full_q);
  end

  // Write-domain state.
  always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
    if (!i_wr_rst_n) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      wr_count_q <= '0;
      wr_full_q  <= 1'b0;
      wr_afull_q <= 1'b0;
      wr_ovf_q   <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      wr_count_q <= wr_count_d;
      wr_full_q  <= wr_full_d;
      wr_afull_q <= wr_afull_d;
      wr_ovf_q   <= wr_ovf_d;
    end
  end

  // Reader: mirror of the writer against the synchronised write pointer.
  always_comb begin
    rd_accept_s = i_read && !rd_empty_q;
    if (rd_accept_s) begin
      rd_bin_d = rd_bin_q + PTR_ONE;
    end else begin
      rd_bin_d = rd_bin_q;
    end
    rd_gray_d     = PW'(bin2gray(32'(rd_bin_d), PW));
    wr_bin_sync_s = PW'(gray2bin(32'(wr_gray_sync_s), PW));
    rd_count_d    = wr_bin_sync_s - rd_bin_d;
    rd_empty_d    = (rd_count_d == '0);
    rd_aempty_d   = (rd_count_d <= AEMPTY_LVL);
    rd_unf_d      = rd_unf_q || (i_read && rd_empty_q);
  end

  // Read-domain state; empty flags reset asserted.
  always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
    if (!i_rd_rst_n) begin
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      rd_count_q  <= '0;
      rd_empty_q  <= 1'b1;
      rd_aempty_q <= 1'b1;
      rd_unf_q    <= 1'b0;
    end else begin
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      rd_count_q  <= rd_count_d;
      rd_empty_q  <= rd_empty_d;
      rd_aempty_q <= rd_aempty_d;
      rd_unf_q    <= rd_unf_d;
    end
  end

  // Collect the registered flags into the shared flag record.
  always_comb begin
    flags_s.full         = wr_full_q;
    flags_s.almost_full  = wr_afull_q;
    flags_s.empty        = rd_empty_q;
    flags_s.almost_empty = rd_aempty_q;
  end

  assign o_wr_addr         = wr_bin_q[ADDR_WIDTH-1:0];
  assign o_rd_addr         = rd_bin_q[ADDR_WIDTH-1:0];
  assign o_wr_full         = flags_s.full;
  assign o_wr_almost_full  = flags_s.almost_full;
  assign o_rd_empty        = flags_s.empty;
  assign o_rd_almost_empty = flags_s.almost_empty;
  assign o_wr_count        = wr_count_q;
  assign o_rd_count        = rd_count_q;
  assign o_wr_overflow     = wr_ovf_q;
  assign o_rd_underflow    = rd_unf_q;

endmodule

// File: tb/tb_fifo_async_ctrl.sv
// Scoreboard bench for fifo_async_ctrl with a behavioural RAM addressed by the DUT.
`timescale 1ns/1ps
module tb_fifo_async_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          wr_clk = 1'b0;
  logic          rd_clk = 1'b0;
  real           wr_half = 5.0;
  real           rd_half = 5.0;
  logic          i_wr_rst_n, i_rd_rst_n, i_write, i_read;
  logic [AW-1:0] o_wr_addr, o_rd_addr;
  logic          o_wr_full, o_wr_almost_full, o_rd_empty, o_rd_almost_empty;
  logic [AW:0]   o_wr_count, o_rd_count;
  logic          o_wr_overflow, o_rd_underflow;

  logic [15:0]   mem [DEPTH];
  logic [15:0]   sb [$];
  logic [15:0]   data_ctr = 16'h0100;
  int            n_tests = 0;
  int            n_fail  = 0;

  fifo_async_ctrl #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .N_FLOP_CROSS(2),
    .ALMOST_WR_MARGIN(1), .ALMOST_RD_MARGIN(1)
  ) dut (
    .i_wr_clk(wr_clk), .i_wr_rst_n(i_wr_rst_n), .i_rd_clk(rd_clk), .i_rd_rst_n(i_rd_rst_n),
    .i_write(i_write), .i_read(i_read), .o_wr_addr(o_wr_addr), .o_rd_addr(o_rd_addr),
    .o_wr_full(o_wr_full), .o_wr_almost_full(o_wr_almost_full),
    .o_rd_empty(o_rd_empty), .o_rd_almost_empty(o_rd_almost_empty),
    .o_wr_count(o_wr_count), .o_rd_count(o_rd_count),
    .o_wr_overflow(o_wr_overflow), .o_rd_underflow(o_rd_underflow)
  );

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push();
    mem[o_wr_addr] = data_ctr;
    sb.push_back(data_ctr);
    data_ctr++;
  endtask

  task automatic sb_pop();
    logic [15:0] e;
    chk("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_data", 32'(mem[o_rd_addr]), 32'(e));
    end
  endtask

  // Called just after a write-clock edge; returns just after the next one.
  task automatic wr_drive(input logic req);
    i_write = req;
    if (req && !o_wr_full) sb_push();
    @(posedge wr_clk); #1;
    i_write = 1'b0;
  endtask

  task automatic rd_drive(input logic req);
    i_read = req;
    if (req && !o_rd_empty) sb_pop();
    @(posedge rd_clk); #1;
    i_read = 1'b0;
  endtask

  task automatic do_reset();
    i_write = 1'b0; i_read = 1'b0;
    i_wr_rst_n = 1'b0; i_rd_rst_n = 1'b0;
    sb.delete();
    #100;
    i_wr_rst_n = 1'b1; i_rd_rst_n = 1'b1;
    @(posedge wr_clk); #1;
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_empty"},  32'(o_rd_empty), 1);
    chk({pfx, "_aempty"}, 32'(o_rd_almost_empty), 1);
    chk({pfx, "_full"},   32'(o_wr_full), 0);
    chk({pfx, "_afull"},  32'(o_wr_almost_full), 0);
    chk({pfx, "_wrcnt"},  32'(o_wr_count), 0);
    chk({pfx, "_rdcnt"},  32'(o_rd_count), 0);
    chk({pfx, "_wraddr"}, 32'(o_wr_addr), 0);
    chk({pfx, "_rdaddr"}, 32'(o_rd_addr), 0);
    chk({pfx, "_ovf"},    32'(o_wr_overflow), 0);
    chk({pfx, "_unf"},    32'(o_rd_underflow), 0);
  endtask

  initial begin
    int wr_left, rd_done, wr_wraps, rd_wraps, false_full;
    logic [AW-1:0] pw, pr;

    do_reset();
    check_reset_state("s1");

    // fill to full, then one rejected write
    for (int i = 1; i <= 9; i++) begin
      wr_drive(1'b1);
      if (i == 6) chk("s2_afull_6", 32'(o_wr_almost_full), 0);
      if (i == 7) begin
        chk("s2_afull_7", 32'(o_wr_almost_full), 1);
        chk("s2_full_7",  32'(o_wr_full), 0);
        chk("s2_cnt_7",   32'(o_wr_count), 7);
      end
      if (i == 8) begin
        chk("s2_full_8", 32'(o_wr_full), 1);
        chk("s2_cnt_8",  32'(o_wr_count), 8);
        chk("s2_ovf_8",  32'(o_wr_overflow), 0);
      end
      if (i == 9) begin
        chk("s2_ovf_9",  32'(o_wr_overflow), 1);
        chk("s2_addr_9", 32'(o_wr_addr), 0);
        chk("s2_cnt_9",  32'(o_wr_count), 8);
      end
    end

    for (int k = 0; k < 10 && o_rd_count != 4'd8; k++) begin
      @(posedge rd_clk); #1;
    end
    chk("s2_rdcnt", 32'(o_rd_count), 8);
    for (int i = 0; i < 8; i++) rd_drive(1'b1);
    chk("s4_empty",  32'(o_rd_empty), 1);
    chk("s4_addr0",  32'(o_rd_addr), 0);
    chk("s4_unf0",   32'(o_rd_underflow), 0);
    rd_drive(1'b1);
    chk("s4_unf",    32'(o_rd_underflow), 1);
    chk("s4_addr1",  32'(o_rd_addr), 0);
    repeat (3) rd_drive(1'b0);
    chk("s4_sticky", 32'(o_rd_underflow), 1);
    for (int k = 0; k < 10 && o_wr_count != 4'd0; k++) begin
      @(posedge wr_clk); #1;
    end
    chk("s2_wrcnt_drained", 32'(o_wr_count), 0);
    chk("s2_full_clear",    32'(o_wr_full), 0);

    // single write crossing latency
    do_reset();
    check_reset_state("s3rst");
    wr_drive(1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge rd_clk); #1;
      if (k < 3) chk("s3_empty_early", 32'(o_rd_empty), 1);
    end
    chk("s3_empty",  32'(o_rd_empty), 0);
    chk("s3_rdcnt",  32'(o_rd_count), 1);
    chk("s3_aempty", 32'(o_rd_almost_empty), 1);
    rd_drive(1'b1);
    chk("s3_empty_after", 32'(o_rd_empty), 1);

    // interleaved traffic with equal clocks
    wr_left = 20; rd_done = 0; wr_wraps = 0; rd_wraps = 0; false_full = 0;
    for (int cyc = 0; cyc < 100 && rd_done < 20; cyc++) begin
      chk("s5_rdcnt_le", 32'(32'(o_rd_count) <= sb.size()), 1);
      chk("s5_wrcnt_ge", 32'(32'(o_wr_count) >= sb.size()), 1);
      if (o_wr_full) false_full++;
      pw = o_wr_addr; pr = o_rd_addr;
      i_write = (wr_left > 0);
      if (i_write && !o_wr_full) begin
        sb_push();
        wr_left--;
      end
      i_read = !o_rd_empty;
      if (i_read) begin
        sb_pop();
        rd_done++;
      end
      @(posedge wr_clk); #1;
      if (pw == 3'd7 && o_wr_addr == 3'd0) wr_wraps++;
      if (pr == 3'd7 && o_rd_addr == 3'd0) rd_wraps++;
    end
    i_write = 1'b0; i_read = 1'b0;
    chk("s5_reads",      32'(rd_done), 20);
    chk("s5_wr_wraps",   32'(wr_wraps), 2);
    chk("s5_rd_wraps",   32'(rd_wraps), 2);
    chk("s5_false_full", 32'(false_full), 0);
    chk("s5_ovf",        32'(o_wr_overflow), 0);

    // unrelated clocks, random traffic
    rd_half = 13.5;
    do_reset();
    fork
      begin
        for (int i = 0; i < 5000; i++) begin
          chk("s6_wrcnt", 32'(o_wr_count <= 4'd8 && 32'(o_wr_count) >= sb.size()), 1);
          wr_drive($urandom_range(0, 1) == 1 && !o_wr_full);
        end
      end
      begin
        @(posedge rd_clk); #1;
        for (int j = 0; j < 1900; j++) begin
          chk("s6_rdcnt", 32'(o_rd_count <= 4'd8 && 32'(o_rd_count) <= sb.size()), 1);
          rd_drive($urandom_range(0, 1) == 1 && !o_rd_empty);
        end
      end
    join
    for (int k = 0; k < 200 && sb.size() > 0; k++) rd_drive(!o_rd_empty);
    chk("s6_drained", 32'(sb.size()), 0);
    chk("s6_empty",   32'(o_rd_empty), 1);
    chk("s6_ovf",     32'(o_wr_overflow), 0);
    chk("s6_unf",     32'(o_rd_underflow), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
